// File: rtl/dmem_stage_ctrl.sv
// dmem_stage_ctrl: memory-stage request/grant/response sequencer.
// Optional access timeout enabled by defining DMEM_CTRL_TIMEOUT_EN.
module dmem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memr_in,
    input  logic        memw_in,
    input  logic        flush,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        pipe_enable,
    output logic        mem_done,
    output logic        busy,
    output logic [31:0] stall_cycles,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t state;
    logic   we_q;
    logic   kill_q;
    logic   mem_op;
    logic   to_hit;

    // The wait counter must be able to reach the timeout limit.
    if ((1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_chk
        $error("dmem_stage_ctrl: CNT_W too small for TIMEOUT_CYCLES");
    end

    assign mem_op = memr_in | memw_in;
    assign busy   = (state != IDLE);

`ifdef DMEM_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             terr_q;

    // Limit reached with no completing response in this cycle.
    assign to_hit = (wait_cnt == TO_LIMIT) &&
                    ((state == REQ) ||
                     ((state == RESP) && !dmem_rvalid));

    assign timeout_err = terr_q;

    // Wait counter runs in REQ/RESP; error is sticky until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            terr_q   <= 1'b0;
        end else begin
            if (state == IDLE)
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + 1'b1;
            if (to_hit)
                terr_q <= 1'b1;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Handshake outputs and the pipeline freeze.
    always_comb begin
        dmem_req    = 1'b0;
        pipe_enable = 1'b0;
        mem_done    = 1'b0;
        unique case (state)
            IDLE: pipe_enable = !mem_op | flush;
            REQ: begin
                dmem_req    = !to_hit;
                pipe_enable = to_hit;
            end
            RESP: begin
                pipe_enable = dmem_rvalid | to_hit;
                mem_done    = dmem_rvalid & !kill_q & !flush;
            end
            default: pipe_enable = 1'b0;
        endcase
        dmem_we = dmem_req & we_q;
    end

    // Access sequencer; a load+store flag pair is taken as a store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            we_q   <= 1'b0;
            kill_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mem_op && !flush) begin
                        state  <= REQ;
                        we_q   <= memw_in;
                        kill_q <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush)
                        kill_q <= 1'b1;
                    if (to_hit)
                        state <= IDLE;
                    else if (dmem_gnt)
                        state <= RESP;
                end
                RESP: begin
                    if (flush)
                        kill_q <= 1'b1;
                    if (dmem_rvalid || to_hit)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of frozen cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cycles <= '0;
        else if (!pipe_enable && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: doc/dmem_stage_ctrl.md
# dmem_stage_ctrl

Sequencer for the memory stage of the pipeline.
- Watches the `memr`/`memw` flags leaving the ALU→DMEM stage register.
- Drives the data-memory request/grant/response handshake.
- Produces the shared `enable` that freezes the pipeline stage registers while an access is outstanding.
- Tracks flushes of the in-flight instruction and counts stall cycles.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles an access may spend in REQ+RESP. Used only with `DMEM_CTRL_TIMEOUT_EN`.
- `CNT_W`, default 8: width of the internal wait counter. Must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `memr_in` in 1: load flag from the ALU→DMEM stage register output.
- `memw_in` in 1: store flag from the ALU→DMEM stage register output.
- `flush` in 1: kill the instruction currently in the DMEM stage (branch/exception).
- `dmem_gnt` in 1: memory accepted the request.
- `dmem_rvalid` in 1: memory response/ack for the accepted request.
- `dmem_req` out 1: request to data memory.
- `dmem_we` out 1: write enable, qualified by `dmem_req`.
- `pipe_enable` out 1: enable for all stage registers up to and including ALU→DMEM.
- `mem_done` out 1: one-cycle pulse; load/store completed and is not killed.
- `busy` out 1: FSM not in IDLE.
- `stall_cycles` out 32: saturating count of cycles with `pipe_enable`=0.
- `timeout_err` out 1: sticky access timeout; tied 0 without the macro.

## Operation
Definition: `mem_op` = `memr_in` | `memw_in`. FSM states: IDLE, REQ, RESP.

IDLE
- `dmem_req`=0.
- `pipe_enable` = !`mem_op` | `flush`.
- If `mem_op` & !`flush`: go to REQ, latch `we_q` = `memw_in`, clear `kill_q`, clear the wait counter.
- If `memr_in` and `memw_in` are both 1, treat as a store.

REQ
- `dmem_req`=1, `dmem_we`=`we_q`, `pipe_enable`=0.
- On `dmem_gnt`: go to RESP.
- `flush` sets `kill_q`. The request is never retracted before grant.

RESP
- `dmem_req`=0, `dmem_we`=0.
- `pipe_enable`=0 until `dmem_rvalid`. In the `dmem_rvalid` cycle, `pipe_enable`=1 (combinational) and next state is IDLE.
- `mem_done` = `dmem_rvalid` & !`kill_q` & !`flush`.
- `flush` sets `kill_q`.

Other rules:
- `dmem_gnt` is ignored outside REQ. `dmem_rvalid` is ignored outside RESP.
- `busy` = (state != IDLE).
- `stall_cycles` increments on each clock with `pipe_enable`=0 and holds at 0xFFFF_FFFF.

## Timing
- Reset (async, `rst`=0): state=IDLE, `dmem_req`=0, `dmem_we`=0, `busy`=0, `mem_done`=0, `stall_cycles`=0, `timeout_err`=0, `kill_q`=0.
  - `pipe_enable` follows the IDLE equation: 1 when `mem_op`=0.
  - Reset asserted in REQ or RESP drops `dmem_req` immediately. The outstanding response is abandoned.
- Best-case access (grant in first REQ cycle, rvalid in first RESP cycle):
  - Cycle 0: IDLE, `mem_op` seen.
  - Cycle 1: REQ, grant.
  - Cycle 2: RESP, rvalid.
  - Result: `pipe_enable` low for 2 cycles (cycles 0–1), high in cycle 2, `stall_cycles` +2.
- Each extra grant-wait or response-wait cycle adds 1 stall cycle.
- Back-to-back memory ops: the next instruction appears at the register output in the cycle after the RESP→IDLE transition. That cycle is IDLE with `mem_op`=1, so the new access starts immediately. No idle gap is inserted beyond that IDLE cycle.
- `flush` and `dmem_rvalid` in the same RESP cycle: `mem_done`=0, transition to IDLE, `pipe_enable`=1.
- `flush` in IDLE with `mem_op`: no request is issued, `pipe_enable`=1, and the killed op leaves the stage.

## Configuration
- `DMEM_CTRL_TIMEOUT_EN` defined:
  - The wait counter increments every cycle in REQ or RESP.
  - If the counter equals `TIMEOUT_CYCLES`-1 and the completing event (`dmem_rvalid` in RESP) is absent that cycle: force IDLE next cycle, assert `pipe_enable`=1 for that cycle, keep `mem_done`=0, drop `dmem_req`, and set `timeout_err` sticky until reset.
  - Completion in the same cycle as the limit wins: normal completion, no error.
- `DMEM_CTRL_TIMEOUT_EN` not defined: no counter, the FSM waits indefinitely, and `timeout_err` is constant 0.

## Test plan
- Non-memory stream (`memr_in`=`memw_in`=0) for 10 cycles → `pipe_enable`=1 throughout, `dmem_req`=0, `stall_cycles`=0.
- Load with `dmem_gnt` in the first REQ cycle and `dmem_rvalid` 3 cycles after grant → `dmem_req` high 1 cycle, `dmem_we`=0, 4 stall cycles, one `mem_done` pulse in the rvalid cycle.
- Store with `dmem_gnt` delayed 2 cycles → `dmem_req` high 3 cycles with `dmem_we`=1; `flush` pulsed in RESP → `mem_done`=0 at rvalid, FSM returns to IDLE.
- Two back-to-back loads, each with 0-wait grant and response → two REQ phases separated by exactly one IDLE cycle, `stall_cycles`=4, two `mem_done` pulses.
- `rst` pulled low during RESP → `busy`=0 and `dmem_req`=0 asynchronously; after release, a late `dmem_rvalid` is ignored and no `mem_done` pulse appears.
- With the macro and `TIMEOUT_CYCLES`=4, no `dmem_gnt` → `timeout_err`=1 after 4 REQ cycles, FSM in IDLE, `timeout_err` stays 1 until `rst`.
